// File: rtl/dvp_pkg.sv
// ----------------------------------------------------------------------------
// dvp_pkg : shared state encoding, helpers and default DVP raster timing
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dvp_pkg;

  typedef enum logic [2:0] {
    DVP_ST_IDLE   = 3'd0,
    DVP_ST_VSYNC  = 3'd1,
    DVP_ST_VBP    = 3'd2,
    DVP_ST_ACTIVE = 3'd3,
    DVP_ST_VFP    = 3'd4
  } dvp_tx_state_t;

  // VGA-like 640x480 raster, also consumed by the receiver bench
  localparam int DVP_H_ACTIVE    = 640;
  localparam int DVP_H_BLANK     = 144;
  localparam int DVP_V_ACTIVE    = 480;
  localparam int DVP_VSYNC_LINES = 3;
  localparam int DVP_VBP_LINES   = 17;
  localparam int DVP_VFP_LINES   = 10;

  function automatic logic dvp_polarity(input logic active, input bit active_high);
    return active_high ? active : ~active;
  endfunction

  function automatic int dvp_cnt_width(input int count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

  function automatic int dvp_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dvp_transmitter_if.sv
// ----------------------------------------------------------------------------
// dvp_transmitter_if : AXI4-Stream byte channel feeding the DVP transmitter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface dvp_transmitter_if;

  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );

endinterface

`default_nettype wire

// File: rtl/dvp_raster_gen.sv
// ----------------------------------------------------------------------------
// dvp_raster_gen : free-running frame FSM, h/v counters and pixel-slot decode.
// Optional feature macro: DVP_TX_SYNC_CHECK_EN. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dvp_raster_gen
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE    = DVP_H_ACTIVE,
  parameter int H_BLANK     = DVP_H_BLANK,
  parameter int V_ACTIVE    = DVP_V_ACTIVE,
  parameter int VSYNC_LINES = DVP_VSYNC_LINES,
  parameter int VBP_LINES   = DVP_VBP_LINES,
  parameter int VFP_LINES   = DVP_VFP_LINES
) (
  input  logic pclk,
  input  logic rst,
  input  logic tvalid,
  input  logic tuser,
  output logic idle,
  output logic slot,
  output logic last_slot,
  output logic vsync_nxt,
  output logic first_beat,
  output logic abort
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int HW      = dvp_cnt_width(H_TOTAL);
  localparam int V_MAX   = dvp_max(dvp_max(V_ACTIVE, VSYNC_LINES),
                                   dvp_max(VBP_LINES, VFP_LINES));
  localparam int VW      = dvp_cnt_width(V_MAX);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0] VS_LAST    = VW'(VSYNC_LINES - 1);
  localparam logic [VW-1:0] VBP_LAST   = VW'(VBP_LINES - 1);
  localparam logic [VW-1:0] VA_LAST    = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VFP_LAST   = VW'(VFP_LINES - 1);

  localparam logic [2:0] ST_IDLE   = DVP_ST_IDLE;
  localparam logic [2:0] ST_VSYNC  = DVP_ST_VSYNC;
  localparam logic [2:0] ST_VBP    = DVP_ST_VBP;
  localparam logic [2:0] ST_ACTIVE = DVP_ST_ACTIVE;
  localparam logic [2:0] ST_VFP    = DVP_ST_VFP;

  logic [2:0]    st_q, st_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          line_end;
  logic          blank_q;
  logic          slot_raw;

  assign line_end = (hcnt_q == H_LAST);

  // Next raster position; outputs are registered from this, so the bus
  // shows exactly the position held in the state registers.
  always_comb begin
    st_d   = st_q;
    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (line_end) begin
      hcnt_d = '0;
      vcnt_d = vcnt_q + 1'b1;
    end
    case (st_q)
      ST_IDLE: begin
        hcnt_d = '0;
        vcnt_d = '0;
        if (tvalid && tuser) st_d = ST_VSYNC;
      end
      ST_VSYNC: begin
        if (line_end && (vcnt_q == VS_LAST)) begin
          st_d   = ST_VBP;
          vcnt_d = '0;
        end
      end
      ST_VBP: begin
        if (line_end && (vcnt_q == VBP_LAST)) begin
          st_d   = ST_ACTIVE;
          vcnt_d = '0;
        end
      end
      ST_ACTIVE: begin
        // A blanked line means a stray start-of-frame: resync via IDLE
        if (line_end && (blank_q || (vcnt_q == VA_LAST))) begin
          st_d   = blank_q ? ST_IDLE : ST_VFP;
          vcnt_d = '0;
        end
      end
      ST_VFP: begin
        if (line_end && (vcnt_q == VFP_LAST)) begin
          st_d   = ST_IDLE;
          vcnt_d = '0;
        end
      end
      default: begin
        st_d   = ST_IDLE;
        hcnt_d = '0;
        vcnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      st_q   <= st_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign slot_raw  = (st_d == ST_ACTIVE) && (hcnt_d <= H_ACT_LAST) && !blank_q;
  assign slot      = slot_raw && !abort;
  assign last_slot = (hcnt_d == H_ACT_LAST);
  assign vsync_nxt = (st_d == ST_VSYNC);
  assign idle      = (st_q == ST_IDLE);

`ifdef DVP_TX_SYNC_CHECK_EN
  logic first_q;

  assign abort      = slot_raw && tvalid && tuser && !first_q;
  assign first_beat = first_q;

  always_ff @(posedge pclk) begin
    if (rst) begin
      blank_q <= 1'b0;
      first_q <= 1'b0;
    end else begin
      if (abort) begin
        blank_q <= 1'b1;
      end else if (line_end) begin
        blank_q <= 1'b0;
      end
      if ((st_q == ST_IDLE) && (st_d == ST_VSYNC)) begin
        first_q <= 1'b1;
      end else if (slot && tvalid) begin
        first_q <= 1'b0;
      end
    end
  end
`else
  assign abort      = 1'b0;
  assign first_beat = 1'b0;
  assign blank_q    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/dvp_transmitter.sv
// ----------------------------------------------------------------------------
// dvp_transmitter : AXI4-Stream to DVP (8-bit, HREF, VSYNC) camera bus driver.
// Optional feature macro: DVP_TX_SYNC_CHECK_EN (tlast/tuser checking). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dvp_transmitter
  import dvp_pkg::*;
#(
  parameter bit VSYNC_ACTIVE_HIGH = 1'b0,
  parameter bit HREF_ACTIVE_HIGH  = 1'b1,
  parameter int H_ACTIVE          = DVP_H_ACTIVE,
  parameter int H_BLANK           = DVP_H_BLANK,
  parameter int V_ACTIVE          = DVP_V_ACTIVE,
  parameter int VSYNC_LINES       = DVP_VSYNC_LINES,
  parameter int VBP_LINES         = DVP_VBP_LINES,
  parameter int VFP_LINES         = DVP_VFP_LINES
) (
  input  logic                pclk,
  input  logic                rst,
  dvp_transmitter_if.slave    axis,
  output logic [7:0]          dout,
  output logic                href_out,
  output logic                vsync_out,
  output logic                underflow,
`ifdef DVP_TX_SYNC_CHECK_EN
  output logic                sync_err,
`endif
  input  logic                err_clr
);

  logic idle;
  logic slot;
  logic last_slot;
  logic vsync_nxt;
  logic first_beat;
  logic abort;
  logic accept;

  dvp_raster_gen #(
    .H_ACTIVE    (H_ACTIVE),
    .H_BLANK     (H_BLANK),
    .V_ACTIVE    (V_ACTIVE),
    .VSYNC_LINES (VSYNC_LINES),
    .VBP_LINES   (VBP_LINES),
    .VFP_LINES   (VFP_LINES)
  ) u_raster (
    .pclk       (pclk),
    .rst        (rst),
    .tvalid     (axis.tvalid),
    .tuser      (axis.tuser),
    .idle       (idle),
    .slot       (slot),
    .last_slot  (last_slot),
    .vsync_nxt  (vsync_nxt),
    .first_beat (first_beat),
    .abort      (abort)
  );

  // In IDLE, beats that are not a frame start are drained so the source
  // can reach its next tuser beat.
  assign axis.tready = !rst && (slot || (idle && axis.tvalid && !axis.tuser));
  assign accept      = slot && axis.tvalid;

  always_ff @(posedge pclk) begin
    if (rst) begin
      dout      <= 8'h00;
      href_out  <= dvp_polarity(1'b0, HREF_ACTIVE_HIGH);
      vsync_out <= dvp_polarity(1'b0, VSYNC_ACTIVE_HIGH);
      underflow <= 1'b0;
    end else begin
      dout      <= accept ? axis.tdata : 8'h00;
      href_out  <= dvp_polarity(slot, HREF_ACTIVE_HIGH);
      vsync_out <= dvp_polarity(vsync_nxt, VSYNC_ACTIVE_HIGH);
      underflow <= (slot && !axis.tvalid) || (underflow && !err_clr);
    end
  end

`ifdef DVP_TX_SYNC_CHECK_EN
  logic sync_evt;

  assign sync_evt = abort
                 || (accept && (axis.tlast != last_slot))
                 || (accept && first_beat && !axis.tuser);

  always_ff @(posedge pclk) begin
    if (rst) begin
      sync_err <= 1'b0;
    end else begin
      sync_err <= sync_evt || (sync_err && !err_clr);
    end
  end
`else
  logic unused_sync;
  assign unused_sync = &{1'b0, axis.tlast, last_slot, first_beat, abort};
`endif

endmodule

`default_nettype wire

// File: tb/tb_dvp_transmitter.sv
// ----------------------------------------------------------------------------
// tb_dvp_transmitter : directed bench on a 4x2 raster (H_TOTAL=6). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dvp_transmitter;

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       err_clr = 1'b0;
  logic [7:0] dout;
  logic       href_out;
  logic       vsync_out;
  logic       underflow;
`ifdef DVP_TX_SYNC_CHECK_EN
  logic       sync_err;
`endif

  dvp_transmitter_if bus ();

  dvp_transmitter #(
    .VSYNC_ACTIVE_HIGH (1'b0),
    .HREF_ACTIVE_HIGH  (1'b1),
    .H_ACTIVE          (4),
    .H_BLANK           (2),
    .V_ACTIVE          (2),
    .VSYNC_LINES       (1),
    .VBP_LINES         (1),
    .VFP_LINES         (1)
  ) dut (
    .pclk      (pclk),
    .rst       (rst),
    .axis      (bus),
    .dout      (dout),
    .href_out  (href_out),
    .vsync_out (vsync_out),
    .underflow (underflow),
`ifdef DVP_TX_SYNC_CHECK_EN
    .sync_err  (sync_err),
`endif
    .err_clr   (err_clr)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gap_cyc = -1;
  bit src_on = 1'b0;
  logic [7:0] sd[$];
  logic       su[$];
  logic       sl[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic drive();
    if (src_on && sd.size() > 0 && cyc != gap_cyc) begin
      bus.tvalid = 1'b1;
      bus.tdata  = sd[0];
      bus.tuser  = su[0];
      bus.tlast  = sl[0];
    end else begin
      bus.tvalid = 1'b0;
      bus.tdata  = 8'h00;
      bus.tuser  = 1'b0;
      bus.tlast  = 1'b0;
    end
  endtask

  // Advance one pclk; the source pops a beat when the previous cycle handshook
  task automatic step();
    logic fire;
    fire = bus.tvalid && bus.tready;
    @(posedge pclk);
    #1;
    if (fire) begin
      void'(sd.pop_front());
      void'(su.pop_front());
      void'(sl.pop_front());
    end
    cyc++;
    drive();
    #1;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic load(input logic [7:0] base, input int n, input int user2, input int la, input int lb);
    sd.delete(); su.delete(); sl.delete();
    for (int i = 0; i < n; i++) begin
      sd.push_back(base + 8'(i));
      su.push_back((i == 0) || (i == user2));
      sl.push_back((i == la) || (i == lb));
    end
  endtask

  // After this returns, cycle 0 is the first cycle with rst low
  task automatic do_reset();
    rst = 1'b1;
    err_clr = 1'b0;
    src_on = 1'b0;
    gap_cyc = -1;
    sd.delete(); su.delete(); sl.delete();
    cyc = -1;
    drive();
    repeat (2) @(posedge pclk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic start_src();
    src_on = 1'b1;
    drive();
    #1;
  endtask

  initial begin
    // ---------------- frame start + full frame ----------------
    do_reset();
    load(8'h10, 8, -1, 3, 7);
    start_src();
    check("rst_tready", bus.tready, 0);
    check("rst_vsync", vsync_out, 1);
    check("rst_href", href_out, 0);
    check("rst_dout", dout, 8'h00);
    check("rst_underflow", underflow, 0);
    step();
    check("vsync_c1", vsync_out, 0);
    run_to(6);
    check("vsync_c6", vsync_out, 0);
    step();
    check("vsync_c7", vsync_out, 1);
    run_to(12);
    check("tready_c12", bus.tready, 1);
    check("href_c12", href_out, 0);
    step();
    check("href_c13", href_out, 1);
    check("dout_c13", dout, 8'h10);
    run_to(16);
    check("dout_c16", dout, 8'h13);
    check("tready_c16", bus.tready, 0);
    step();
    check("href_c17", href_out, 0);
    check("dout_c17", dout, 8'h00);
    run_to(19);
    check("dout_c19", dout, 8'h14);
    run_to(22);
    check("dout_c22", dout, 8'h17);
    check("href_c22", href_out, 1);
    step();
    check("href_c23", href_out, 0);
    check("full_underflow", underflow, 0);
`ifdef DVP_TX_SYNC_CHECK_EN
    check("full_sync_err", sync_err, 0);
`endif
    run_to(32);
    check("idle_vsync_c32", vsync_out, 1);

    // ---------------- underflow ----------------
    do_reset();
    load(8'h20, 8, -1, 3, 7);
    gap_cyc = 14;
    start_src();
    run_to(14);
    check("uf_dout_c14", dout, 8'h21);
    check("uf_flag_c14", underflow, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("uf_dout_c15", dout, 8'h00);
    check("uf_href_c15", href_out, 1);
    check("uf_set_wins", underflow, 1);
    step();
    check("uf_dout_c16", dout, 8'h22);
    run_to(19);
    check("uf_dout_c19", dout, 8'h23);
    run_to(31);
    check("idle_discard", bus.tready, 1);
    step();
    check("idle_empty", bus.tready, 0);
    check("uf_sticky", underflow, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("uf_clear", underflow, 0);

    // ---------------- reset mid-line ----------------
    do_reset();
    load(8'h30, 8, -1, 3, 7);
    start_src();
    run_to(14);
    check("rml_dout_c14", dout, 8'h31);
    rst = 1'b1;
    step();
    rst = 1'b0;
    src_on = 1'b0;
    drive();
    #1;
    check("rml_href", href_out, 0);
    check("rml_vsync", vsync_out, 1);
    check("rml_dout", dout, 8'h00);
    check("rml_tready", bus.tready, 0);
    load(8'h50, 1, -1, -1, -1);
    start_src();
    step();
    check("rml_idle_restart", vsync_out, 0);

`ifdef DVP_TX_SYNC_CHECK_EN
    // ---------------- early tlast ----------------
    do_reset();
    load(8'h60, 8, -1, 2, 7);
    start_src();
    run_to(14);
    check("se_tlast_c14", sync_err, 0);
    step();
    check("se_tlast_c15", sync_err, 1);

    // ---------------- mid-frame tuser ----------------
    do_reset();
    load(8'h40, 4, 2, 3, -1);
    start_src();
    run_to(14);
    check("mt_tready_c14", bus.tready, 0);
    check("mt_dout_c14", dout, 8'h41);
    step();
    check("mt_href_c15", href_out, 0);
    check("mt_sync_err", sync_err, 1);
    run_to(18);
    check("mt_href_c18", href_out, 0);
    step();
    check("mt_vsync_c19", vsync_out, 1);
    step();
    check("mt_vsync_c20", vsync_out, 0);
    run_to(32);
    check("mt_href_c32", href_out, 1);
    check("mt_dout_c32", dout, 8'h42);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
